// File: rtl/tdc_packetizer.sv
// Buffers TDC result words in a small FIFO and frames each one as HEADER, SEQ, data bytes (MSB first), CHK.
// First header byte two cycles after the word is pushed; oByte holds while stalled, back-to-back frames without bubbles.
module tdc_packetizer #(
  parameter int         DIG_OUT = 32,
  parameter int         DEPTH   = 16,
  parameter logic [7:0] HEADER  = 8'hA5
) (
  input  logic                     clk,
  input  logic                     iRst_n,
  input  logic [DIG_OUT-1:0]       iData,
  input  logic                     iValid,
  input  logic                     iClrOvf,
  output logic [7:0]               oByte,
  output logic                     oByteValid,
  input  logic                     iByteReady,
  output logic                     oEmpty,
  output logic                     oFull,
  output logic [$clog2(DEPTH):0]   oCount,
  output logic                     oOverflow
);
  localparam int NB = (DIG_OUT + 7) / 8;
  localparam int W  = NB * 8;
  localparam int AW = $clog2(DEPTH);
  localparam int IW = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_SEQ, S_DATA, S_CHK} state_t;

  logic [DIG_OUT-1:0] mem_q [DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]        count_q, count_d;
  logic               ovf_q, ovf_d;
  state_t             state_q, state_d;
  logic [W-1:0]       shreg_q, shreg_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [7:0]         seq_q, seq_d;
  logic [7:0]         chk_q, chk_d;
  logic [7:0]         byte_q, byte_d;
  logic               byte_vld_q, byte_vld_d;

  logic               fifo_empty, fifo_full, xfer, pop, push;
  logic [W-1:0]       head_word;
  logic [7:0]         top_byte;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == (AW+1)'(DEPTH));
  assign xfer       = byte_vld_q & iByteReady;
  assign top_byte   = shreg_q[W-1 -: 8];

  // Zero-extend the head entry so odd widths pad the top data byte.
  always_comb begin
    head_word                = '0;
    head_word[DIG_OUT-1:0]   = mem_q[rd_ptr_q];
  end

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    idx_d      = idx_q;
    seq_d      = seq_q;
    chk_d      = chk_q;
    byte_d     = byte_q;
    byte_vld_d = byte_vld_q;
    pop        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shreg_d = head_word;
          state_d = S_HDR;
        end
      end
      S_HDR: begin
        if (!byte_vld_q) begin
          byte_d     = HEADER;
          byte_vld_d = 1'b1;
        end else if (xfer) begin
          byte_d  = seq_q;
          chk_d   = seq_q;
          state_d = S_SEQ;
        end
      end
      S_SEQ: begin
        if (xfer) begin
          byte_d  = top_byte;
          chk_d   = chk_q ^ top_byte;
          shreg_d = shreg_q << 8;
          idx_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (xfer) begin
          if (idx_q == IW'(NB - 1)) begin
            byte_d  = chk_q;
            state_d = S_CHK;
          end else begin
            byte_d  = top_byte;
            chk_d   = chk_q ^ top_byte;
            shreg_d = shreg_q << 8;
            idx_d   = idx_q + 1'b1;
          end
        end
      end
      S_CHK: begin
        if (xfer) begin
          seq_d = seq_q + 8'd1;
          // Chain straight into the next header so the link sees no idle cycle.
          if (!fifo_empty) begin
            pop     = 1'b1;
            shreg_d = head_word;
            byte_d  = HEADER;
            state_d = S_HDR;
          end else begin
            byte_d     = 8'h00;
            byte_vld_d = 1'b0;
            state_d    = S_IDLE;
          end
        end
      end
      default: begin
        byte_vld_d = 1'b0;
        state_d    = S_IDLE;
      end
    endcase
  end

  always_comb begin
    push     = iValid & (~fifo_full | pop);
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // A drop in the same cycle as a clear still leaves the flag set.
    if (iValid & fifo_full & ~pop) begin
      ovf_d = 1'b1;
    end else if (iClrOvf) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= iData;
    end
  end

  always_ff @(posedge clk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q    <= S_IDLE;
      shreg_q    <= '0;
      idx_q      <= '0;
      seq_q      <= '0;
      chk_q      <= '0;
      byte_q     <= '0;
      byte_vld_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      idx_q      <= idx_d;
      seq_q      <= seq_d;
      chk_q      <= chk_d;
      byte_q     <= byte_d;
      byte_vld_q <= byte_vld_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
    end
  end

  assign oByte      = byte_q;
  assign oByteValid = byte_vld_q;
  assign oEmpty     = fifo_empty;
  assign oFull      = fifo_full;
  assign oCount     = count_q;
  assign oOverflow  = ovf_q;

endmodule

// File: tb/tb_tdc_packetizer.sv
// Bench for tdc_packetizer: frame bytes are queued when a word is driven and popped on every byte transfer.
module tb_tdc_packetizer;
  logic        clk = 1'b0;
  logic        iRst_n = 1'b0;
  logic [31:0] iData = '0;
  logic        iValid = 1'b0;
  logic        iClrOvf = 1'b0;
  logic [7:0]  oByte;
  logic        oByteValid;
  logic        iByteReady = 1'b0;
  logic        oEmpty;
  logic        oFull;
  logic [4:0]  oCount;
  logic        oOverflow;

  always #5 clk = ~clk;

  tdc_packetizer #(.DIG_OUT(32), .DEPTH(16), .HEADER(8'hA5)) dut (
    .clk        (clk),
    .iRst_n     (iRst_n),
    .iData      (iData),
    .iValid     (iValid),
    .iClrOvf    (iClrOvf),
    .oByte      (oByte),
    .oByteValid (oByteValid),
    .iByteReady (iByteReady),
    .oEmpty     (oEmpty),
    .oFull      (oFull),
    .oCount     (oCount),
    .oOverflow  (oOverflow)
  );

  typedef struct {
    logic [31:0] data;
    logic [7:0]  seq;
    logic [7:0]  chk;
    bit          stall;
  } vec_t;

  vec_t        tbl [6];
  int          checks = 0;
  int          errors = 0;
  logic [7:0]  exp_q [$];
  logic [7:0]  seq_model = 8'h00;
  int          rdy_mode = 0;
  int          cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] chk_of(input logic [7:0] s, input logic [31:0] d);
    return s ^ d[31:24] ^ d[23:16] ^ d[15:8] ^ d[7:0];
  endfunction

  task automatic push_frame(input logic [31:0] d, input logic [7:0] s, input logic [7:0] c);
    exp_q.push_back(8'hA5);
    exp_q.push_back(s);
    exp_q.push_back(d[31:24]);
    exp_q.push_back(d[23:16]);
    exp_q.push_back(d[15:8]);
    exp_q.push_back(d[7:0]);
    exp_q.push_back(c);
    seq_model = s + 8'd1;
  endtask

  // Mode 0: ready high, 1: ready pattern 1,0,0, 2: ready low, 3: driven by the test.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    case (rdy_mode)
      0:       iByteReady = 1'b1;
      1:       iByteReady = (cyc % 3 == 0);
      2:       iByteReady = 1'b0;
      default: ;
    endcase
  endtask

  task automatic pulse(input logic [31:0] d, input bit model);
    iValid = 1'b1;
    iData  = d;
    if (model) push_frame(d, seq_model, chk_of(seq_model, d));
    tick();
    iValid = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    bit done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      tick();
      if (exp_q.size() == 0 && !oByteValid && oEmpty) done = 1'b1;
    end
    check("drain", {31'b0, done}, 32'd1);
  endtask

  task automatic do_reset();
    iRst_n = 1'b0;
    #1;
    check("rst_vld", oByteValid, 1'b0);
    check("rst_byte", oByte, 8'h00);
    check("rst_empty", oEmpty, 1'b1);
    check("rst_full", oFull, 1'b0);
    check("rst_count", oCount, 5'd0);
    check("rst_ovf", oOverflow, 1'b0);
    exp_q.delete();
    seq_model = 8'h00;
    iValid    = 1'b0;
    iClrOvf   = 1'b0;
    tick();
    tick();
    iRst_n = 1'b1;
    tick();
  endtask

  // Stream monitor: compares transferred bytes and checks oByte stability under stall.
  bit         stalled = 1'b0;
  logic [7:0] stall_byte;
  logic [7:0] e;
  always @(negedge clk) begin
    if (!iRst_n) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        check("stall_valid", oByteValid, 1'b1);
        check("stall_byte", oByte, stall_byte);
      end
      if (oByteValid && iByteReady) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_byte: got %0h expected no byte", oByte);
        end else begin
          e = exp_q.pop_front();
          check("stream_byte", oByte, e);
        end
      end
      stalled    = oByteValid && !iByteReady;
      stall_byte = oByte;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] da;
    logic [31:0] db;
    tbl[0] = '{data: 32'h12345678, seq: 8'h01, chk: 8'h09, stall: 1'b1};
    tbl[1] = '{data: 32'hDEADBEEF, seq: 8'h02, chk: 8'h20, stall: 1'b0};
    tbl[2] = '{data: 32'h00000000, seq: 8'h03, chk: 8'h03, stall: 1'b0};
    tbl[3] = '{data: 32'hFFFFFFFF, seq: 8'h04, chk: 8'h04, stall: 1'b1};
    tbl[4] = '{data: 32'h01020408, seq: 8'h05, chk: 8'h0A, stall: 1'b0};
    tbl[5] = '{data: 32'hA5A5A5A5, seq: 8'h06, chk: 8'h06, stall: 1'b1};

    rdy_mode = 0;
    do_reset();

    // Single word: latency and 7-cycle frame.
    push_frame(32'h12345678, 8'h00, 8'h08);
    iValid = 1'b1;
    iData  = 32'h12345678;
    tick();
    iValid = 1'b0;
    check("lat_count_k", oCount, 5'd1);
    check("lat_empty_k", oEmpty, 1'b0);
    tick();
    check("lat_vld_k1", oByteValid, 1'b0);
    check("lat_count_k1", oCount, 5'd0);
    tick();
    check("lat_vld_k2", oByteValid, 1'b1);
    check("lat_hdr_k2", oByte, 8'hA5);
    for (int i = 1; i < 7; i++) begin
      tick();
      check("frame_vld", oByteValid, 1'b1);
    end
    tick();
    check("frame_end_vld", oByteValid, 1'b0);
    wait_drain(20);

    for (int i = 0; i < 6; i++) begin
      rdy_mode = tbl[i].stall ? 1 : 0;
      push_frame(tbl[i].data, tbl[i].seq, tbl[i].chk);
      pulse(tbl[i].data, 1'b0);
      wait_drain(200);
    end

    // Overflow: 17 accepted, 18th dropped.
    rdy_mode = 0;
    do_reset();
    rdy_mode = 2;
    tick();
    for (int i = 0; i < 17; i++) pulse($urandom, 1'b1);
    check("ovf_full", oFull, 1'b1);
    check("ovf_count", oCount, 5'd16);
    check("ovf_pre", oOverflow, 1'b0);
    pulse(32'hBAD0BAD0, 1'b0);
    check("ovf_set", oOverflow, 1'b1);
    check("ovf_count_drop", oCount, 5'd16);
    iClrOvf = 1'b1;
    tick();
    iClrOvf = 1'b0;
    check("ovf_clr", oOverflow, 1'b0);
    rdy_mode = 0;
    wait_drain(400);

    // Full FIFO, push coincides with the CHK-transfer pop.
    do_reset();
    rdy_mode   = 3;
    iByteReady = 1'b0;
    for (int i = 0; i < 17; i++) pulse($urandom, 1'b1);
    iByteReady = 1'b1;
    repeat (6) tick();
    check("sim_pre_full", oFull, 1'b1);
    pulse(32'h5EED5EED, 1'b1);
    iByteReady = 1'b0;
    check("sim_count", oCount, 5'd16);
    check("sim_full", oFull, 1'b1);
    check("sim_ovf", oOverflow, 1'b0);
    check("sim_nobubble_vld", oByteValid, 1'b1);
    check("sim_nobubble_hdr", oByte, 8'hA5);
    rdy_mode = 0;
    wait_drain(400);

    // SEQ wrap over 257 frames.
    do_reset();
    for (int n = 0; n < 257; n++) begin
      pulse($urandom, 1'b1);
      wait_drain(40);
    end

    // Reset during DATA byte 2; queued word must be discarded.
    da = 32'hCAFEF00D;
    db = 32'h0BADBEEF;
    pulse(da, 1'b1);
    pulse(db, 1'b1);
    repeat (5) tick();
    check("mid_vld", oByteValid, 1'b1);
    check("mid_byte2", oByte, da[15:8]);
    do_reset();
    pulse(32'h89ABCDEF, 1'b1);
    wait_drain(50);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
